stepper_axis_driver: RTL and testbench

Downstream stage of the motion-control peripheral: one instance per axis (theta, phi) consumes the `pos`/`neg` step-request pair produced by the motion controller. It converts each request into timed stepper-coil phase patterns and keeps a signed-free 16-bit step position. That position is the value software reads back and writes into the controller's `actual` angle register.

---
 rtl/stepper_axis_driver_pkg.sv | 29 ++
 rtl/stepper_axis_driver_if.sv | 26 ++
 rtl/stepper_axis_driver_phase_lut.sv | 18 +
 rtl/stepper_axis_driver.sv | 96 +++++++++
 tb/tb_stepper_axis_driver.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/stepper_axis_driver_pkg.sv
// stepper_pkg: state type, coil sequences and phase width for stepper_axis_driver.
// STEPPER_HALF_STEP_EN selects the 8-entry half-step sequence (3-bit phase).
package stepper_pkg;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_HOLD,
    ST_RUN
  } state_t;

  // Coil words are {A, B, A', B'}
  localparam logic [3:0] FULL_STEP_TBL [4] = '{
    4'b1100, 4'b0110, 4'b0011, 4'b1001
  };

  localparam logic [3:0] HALF_STEP_TBL [8] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

`ifdef STEPPER_HALF_STEP_EN
  localparam int unsigned PHASE_W = 3;
`else
  localparam int unsigned PHASE_W = 2;
`endif

  typedef logic [PHASE_W-1:0] phase_t;

endpackage

// File: rtl/stepper_axis_driver_if.sv
// Axis bundle between the motion controller (master) and one stepper_axis_driver (slave).
interface stepper_axis_driver_if #(
  parameter int unsigned PER_W = 16
);
  logic             en;
  logic             dir_pos;
  logic             dir_neg;
  logic [PER_W-1:0] period;
  logic             pos_load;
  logic [15:0]      pos_in;
  logic [3:0]       coil;
  logic [15:0]      position;
  logic             step_pulse;
  logic             at_limit;
  logic             fault;

  modport master (
    output en, dir_pos, dir_neg, period, pos_load, pos_in,
    input  coil, position, step_pulse, at_limit, fault
  );

  modport slave (
    input  en, dir_pos, dir_neg, period, pos_load, pos_in,
    output coil, position, step_pulse, at_limit, fault
  );
endinterface

// File: rtl/stepper_axis_driver_phase_lut.sv
// stepper_phase_lut: combinational phase -> coil pattern lookup.
// STEPPER_HALF_STEP_EN selects the half-step table.
module stepper_phase_lut
  import stepper_pkg::*;
(
  input  phase_t     phase,
  output logic [3:0] coil
);

  always_comb begin
`ifdef STEPPER_HALF_STEP_EN
    coil = HALF_STEP_TBL[phase];
`else
    coil = FULL_STEP_TBL[phase];
`endif
  end

endmodule

// File: rtl/stepper_axis_driver.sv
// stepper_axis_driver: turns pos/neg step requests into timed coil phases and a step position.
// Build option STEPPER_HALF_STEP_EN (see stepper_pkg) selects half-step sequencing.
module stepper_axis_driver
  import stepper_pkg::*;
#(
  parameter logic [15:0] POS_MAX = 16'd3599,
  parameter int unsigned PER_W   = 16
) (
  input logic                  clk,
  input logic                  rst,
  stepper_axis_driver_if.slave axis
);

  state_t           state;
  state_t           state_nxt;
  logic [PER_W-1:0] cnt;
  phase_t           phase;
  logic [15:0]      position_q;
  logic             step_pulse_q;
  logic             at_limit_q;
  logic             fault_q;
  logic [3:0]       lut_coil;

  logic             one_req;
  logic             run_ok;
  logic             blocked;
  logic             terminal;
  logic             do_step;
  logic [15:0]      load_val;

  assign one_req  = axis.dir_pos ^ axis.dir_neg;
  assign run_ok   = axis.en && one_req && (axis.period != '0);
  assign blocked  = (axis.dir_pos && (position_q == POS_MAX)) ||
                    (axis.dir_neg && (position_q == 16'd0));
  assign load_val = (axis.pos_in > POS_MAX) ? POS_MAX : axis.pos_in;

  stepper_phase_lut u_lut (
    .phase (phase),
    .coil  (lut_coil)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_OFF;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!axis.en) begin
      state_nxt = ST_OFF;
    end else begin
      unique case (state)
        ST_OFF:  state_nxt = ST_HOLD;
        ST_HOLD: if (run_ok)  state_nxt = ST_RUN;
        ST_RUN:  if (!run_ok) state_nxt = ST_HOLD;
        default: state_nxt = ST_OFF;
      endcase
    end
  end

  always_comb begin
    axis.coil = (state == ST_OFF) ? '0 : lut_coil;
    // >= rather than == so a period lowered below the running count fires at once
    terminal  = (cnt >= axis.period - 1'b1);
    do_step   = (state == ST_RUN) && run_ok && terminal && !blocked && !axis.pos_load;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt          <= '0;
      phase        <= '0;
      position_q   <= '0;
      step_pulse_q <= 1'b0;
      at_limit_q   <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      step_pulse_q <= do_step;
      at_limit_q   <= (state != ST_OFF) && axis.en && one_req && blocked;
      if (axis.dir_pos && axis.dir_neg) fault_q <= 1'b1;

      if ((state != ST_RUN) || !run_ok || terminal || axis.pos_load) cnt <= '0;
      else                                                           cnt <= cnt + 1'b1;

      if (axis.pos_load)  position_q <= load_val;
      else if (do_step)   position_q <= axis.dir_pos ? position_q + 16'd1 : position_q - 16'd1;

      if (do_step) phase <= axis.dir_pos ? phase + 1'b1 : phase - 1'b1;
    end
  end

  assign axis.position   = position_q;
  assign axis.step_pulse = step_pulse_q;
  assign axis.at_limit   = at_limit_q;
  assign axis.fault      = fault_q;

endmodule

// File: tb/tb_stepper_axis_driver.sv
// Scoreboard bench for stepper_axis_driver: directed test-plan scenarios, then random stimulus.
module tb_stepper_axis_driver;

  localparam int POS_MAX = 3599;

  typedef struct {
    int coil;
    int position;
    int step_pulse;
    int at_limit;
    int fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stepper_axis_driver_if #(.PER_W(16)) bus ();

  stepper_axis_driver #(.POS_MAX(16'd3599), .PER_W(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .axis (bus)
  );

`ifdef STEPPER_HALF_STEP_EN
  localparam int LEN = 8;
  int seq[LEN] = '{8, 12, 4, 6, 2, 3, 1, 9};
`else
  localparam int LEN = 4;
  int seq[LEN] = '{12, 6, 3, 9};
`endif

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];

  // Reference model: mode 0=off 1=hold 2=run; elapsed = cycles since run entry or last terminal
  int m_mode = 0, m_el = 0, m_ph = 0, m_pos = 0, m_fault = 0, m_lim = 0, m_pulse = 0;

  task automatic chk(input string nm, input logic [31:0] act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit dp, input bit dn,
                            input int per, input bit ld, input int pin);
    exp_t x;
    bit one, blk, stp, active;
    if (!r) begin
      m_mode = 0; m_el = 0; m_ph = 0; m_pos = 0; m_fault = 0; m_lim = 0; m_pulse = 0;
    end else begin
      one    = (dp != dn);
      active = one && (per != 0);
      blk    = (dp && m_pos == POS_MAX) || (dn && m_pos == 0);
      stp    = 0;
      m_lim  = e && (m_mode != 0) && one && blk;
      if (dp && dn) m_fault = 1;
      if (m_mode == 2 && e && active) begin
        if (ld) m_el = 0;
        else if (m_el + 1 >= per) begin
          m_el = 0;
          stp  = !blk;
        end else m_el++;
      end else m_el = 0;
      if (ld) m_pos = (pin > POS_MAX) ? POS_MAX : pin;
      else if (stp) m_pos = dp ? m_pos + 1 : m_pos - 1;
      if (stp) m_ph = (m_ph + (dp ? 1 : LEN - 1)) % LEN;
      m_pulse = stp;
      if (!e) m_mode = 0;
      else if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) begin
        if (active) m_mode = 2;
      end else if (!active) m_mode = 1;
    end
    x.coil       = (m_mode == 0) ? 0 : seq[m_ph];
    x.position   = m_pos;
    x.step_pulse = m_pulse;
    x.at_limit   = m_lim;
    x.fault      = m_fault;
    exp_q.push_back(x);
  endtask

  task automatic drive(input bit r, input bit e, input bit dp, input bit dn,
                       input int per, input bit ld, input int pin);
    @(negedge clk);
    rst          = r;
    bus.en       = e;
    bus.dir_pos  = dp;
    bus.dir_neg  = dn;
    bus.period   = 16'(per);
    bus.pos_load = ld;
    bus.pos_in   = 16'(pin);
    model_step(r, e, dp, dn, per, ld, pin);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every cycle's registered outputs are checked against the queued expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("coil",       32'(bus.coil),       e.coil);
      chk("position",   32'(bus.position),   e.position);
      chk("step_pulse", 32'(bus.step_pulse), e.step_pulse);
      chk("at_limit",   32'(bus.at_limit),   e.at_limit);
      chk("fault",      32'(bus.fault),      e.fault);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int dir;
    bit dp, dn, e, ld, r;
    int per, pin;

    bus.en = 0; bus.dir_pos = 0; bus.dir_neg = 0; bus.period = '0;
    bus.pos_load = 0; bus.pos_in = '0;

    // Reset state
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 4, 0, 0);
    settle();
    chk("reset_position", 32'(bus.position), 0);
    chk("reset_coil",     32'(bus.coil),     0);

    // period=4 stepping from entry 0: five steps over 21 RUN edges
    drive(1, 1, 0, 0, 4, 0, 0);
    pulses = 0;
    for (int i = 0; i < 21; i++) begin
      drive(1, 1, 1, 0, 4, 0, 0);
      settle();
      pulses += int'(bus.step_pulse);
    end
    chk("run_pulses", 32'(pulses), 5);
    chk("run_position", 32'(bus.position), 5);

    // Upper limit after preload
    drive(1, 1, 0, 0, 2, 1, 3598);
    for (int i = 0; i < 10; i++) drive(1, 1, 1, 0, 2, 0, 0);
    settle();
    chk("upper_position", 32'(bus.position), 3599);
    chk("upper_at_limit", 32'(bus.at_limit), 1);

    // Lower limit with period=1
    drive(1, 1, 0, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 1, 1, 0, 0);
    settle();
    chk("lower_position", 32'(bus.position), 0);
    chk("lower_at_limit", 32'(bus.at_limit), 1);

    // Conflicting request mid-RUN
    drive(1, 1, 0, 0, 3, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 3, 0, 0);
    drive(1, 1, 1, 1, 3, 0, 0);
    drive(1, 1, 0, 0, 3, 0, 0);
    drive(1, 1, 0, 0, 3, 0, 0);
    settle();
    chk("fault_sticky", 32'(bus.fault), 1);

    // Preload colliding with terminal count
    drive(1, 1, 0, 0, 4, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 4, 0, 0);
    drive(1, 1, 1, 0, 4, 1, 100);
    settle();
    chk("load_position", 32'(bus.position), 100);
    chk("load_no_pulse", 32'(bus.step_pulse), 0);
    for (int i = 0; i < 6; i++) drive(1, 1, 1, 0, 4, 0, 0);

    // Enable drop mid-RUN then resume; clamp on oversize preload
    drive(1, 0, 1, 0, 4, 0, 0);
    settle();
    chk("off_coil", 32'(bus.coil), 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 4, 0, 0);
    for (int i = 0; i < 8; i++) drive(1, 1, 1, 0, 2, 0, 0);
    drive(1, 1, 0, 0, 2, 1, 40000);
    settle();
    chk("clamp_position", 32'(bus.position), 3599);

    // Random stimulus
    dir = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) dir = $urandom_range(0, 3);
      r  = ($urandom_range(0, 299) != 0);
      e  = ($urandom_range(0, 19) != 0);
      dp = (dir == 1) || (dir == 3 && $urandom_range(0, 3) == 0);
      dn = (dir == 2) || (dir == 3 && $urandom_range(0, 3) == 0);
      per = ($urandom_range(0, 29) == 0) ? 0 : $urandom_range(1, 6);
      ld  = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 5))
        0: pin = $urandom_range(0, 2);
        1: pin = $urandom_range(3596, 3599);
        2: pin = $urandom_range(3600, 65535);
        default: pin = $urandom_range(0, 3599);
      endcase
      drive(r, e, dp, dn, per, ld, pin);
    end

    drive(1, 1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
